// File: rtl/pattern_detect_ctrl.sv
// pattern_detect_ctrl: programmable serial sequence detector.
// A pattern, length and overlap mode are latched through a valid/ready
// config handshake while idle. After arm, qualified serial bits are shifted
// into a history register and compared against the low len bits of the
// pattern. A match produces a registered one-cycle detect pulse and bumps
// a saturating match counter. Non-overlap mode restarts filling after each
// match, so the next match needs len fresh bits.
module pattern_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               arm,
  input  logic               disarm,
  input  logic               in,
  input  logic               in_valid,
  output logic               armed,
  output logic               detect,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t state_reg, state_next;

  logic [MAX_LEN-1:0] pattern_reg, pattern_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic               overlap_reg, overlap_next;
  logic               err_reg, err_next;
  logic [MAX_LEN-1:0] history_reg, history_next;
  logic [LEN_W-1:0]   fill_reg, fill_next;
  logic               detect_reg, detect_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               sat_reg, sat_next;

  // Compare mask: bit gi participates when gi < latched length.
  logic [MAX_LEN-1:0] len_mask;
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign len_mask[gi] = (len_reg > LEN_W'(gi));
    end
  endgenerate

  // Values the datapath would hold after accepting the current bit.
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               bit_match;
  logic               cfg_len_ok;
  logic               latched_len_ok;

  assign hist_shift     = {history_reg[MAX_LEN-2:0], in};
  assign fill_inc       = (fill_reg < len_reg) ? fill_reg + LEN_W'(1) : fill_reg;
  assign bit_match      = (((hist_shift ^ pattern_reg) & len_mask) == '0) &&
                          (fill_inc >= len_reg);
  assign cfg_len_ok     = (cfg_len != '0) && (cfg_len <= MAX_LEN_W);
  assign latched_len_ok = (len_reg != '0) && (len_reg <= MAX_LEN_W);

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pattern_reg <= '0;
      len_reg     <= '0;
      overlap_reg <= 1'b0;
      err_reg     <= 1'b0;
      history_reg <= '0;
      fill_reg    <= '0;
      detect_reg  <= 1'b0;
      count_reg   <= '0;
      sat_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pattern_reg <= pattern_next;
      len_reg     <= len_next;
      overlap_reg <= overlap_next;
      err_reg     <= err_next;
      history_reg <= history_next;
      fill_reg    <= fill_next;
      detect_reg  <= detect_next;
      count_reg   <= count_next;
      sat_reg     <= sat_next;
    end
  end

  // Next-state, config latching, shift/fill, match and counter logic.
  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    len_next     = len_reg;
    overlap_next = overlap_reg;
    err_next     = err_reg;
    history_next = history_reg;
    fill_next    = fill_reg;
    detect_next  = 1'b0;
    count_next   = count_reg;
    sat_next     = sat_reg;

    case (state_reg)
      IDLE: begin
        if (cfg_valid) begin
          // Config wins over a same-cycle arm; arm must come later.
          pattern_next = cfg_pattern;
          len_next     = cfg_len;
          overlap_next = cfg_overlap;
          err_next     = !cfg_len_ok;
        end else if (arm && latched_len_ok && !err_reg) begin
          state_next   = FILL;
          history_next = '0;
          fill_next    = '0;
          count_next   = '0;
          sat_next     = 1'b0;
        end
      end

      FILL, RUN: begin
        if (disarm) begin
          // Disarm beats a same-cycle match: no pulse, no count.
          state_next = IDLE;
        end else if (in_valid) begin
          history_next = hist_shift;
          fill_next    = fill_inc;
          if (bit_match) begin
            detect_next = 1'b1;
            if (count_reg != CNT_MAX) begin
              count_next = count_reg + CNT_W'(1);
              if (count_reg + CNT_W'(1) == CNT_MAX) begin
                sat_next = 1'b1;
              end
            end else begin
              sat_next = 1'b1;
            end
            if (overlap_reg) begin
              state_next = RUN;
            end else begin
              fill_next  = '0;
              state_next = FILL;
            end
          end else begin
            state_next = (fill_inc == len_reg) ? RUN : FILL;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cfg_ready   = (state_reg == IDLE);
  assign armed       = (state_reg != IDLE);
  assign cfg_err     = err_reg;
  assign detect      = detect_reg;
  assign match_count = count_reg;
  assign count_sat   = sat_reg;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Testbench for pattern_detect_ctrl: directed scenarios plus a randomized
// run checked against a bit-queue reference model. Two instances share the
// stimulus: one with an 8-bit counter, one with a 2-bit counter.
module tb_pattern_detect_ctrl;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cfg_valid = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic cfg_overlap = 1'b0;
  logic arm = 1'b0;
  logic disarm = 1'b0;
  logic din = 1'b0;
  logic in_valid = 1'b0;

  logic cfg_ready, cfg_err, armed, detect, count_sat;
  logic [7:0] match_count;
  logic s_cfg_ready, s_cfg_err, s_armed, s_detect, s_count_sat;
  logic [1:0] s_match_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       m_armed, m_err, m_ovl, m_det;
  int       m_len, m_matches, m_fresh;
  bit [7:0] m_pat;
  bit       m_bits[$];

  always #5 clk = ~clk;

  pattern_detect_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(cfg_err), .arm(arm), .disarm(disarm), .in(din), .in_valid(in_valid),
    .armed(armed), .detect(detect), .match_count(match_count), .count_sat(count_sat)
  );

  pattern_detect_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(s_cfg_err), .arm(arm), .disarm(disarm), .in(din), .in_valid(in_valid),
    .armed(s_armed), .detect(s_detect), .match_count(s_match_count), .count_sat(s_count_sat)
  );

  function automatic int exp_cnt(int max);
    return (m_matches > max) ? max : m_matches;
  endfunction

  // Advance one clock; the model sees the same inputs the DUT samples.
  task automatic tick();
    bit hit;
    if (!reset) begin
      m_armed = 0; m_err = 0; m_ovl = 0; m_len = 0; m_pat = '0;
      m_matches = 0; m_fresh = 0; m_det = 0;
    end else if (!m_armed) begin
      m_det = 0;
      if (cfg_valid) begin
        m_pat = cfg_pattern;
        m_len = int'(cfg_len);
        m_ovl = cfg_overlap;
        m_err = (m_len == 0) || (m_len > MAX_LEN);
      end else if (arm && !m_err && m_len >= 1 && m_len <= MAX_LEN) begin
        m_armed = 1; m_fresh = 0; m_matches = 0;
      end
    end else begin
      m_det = 0;
      if (disarm) begin
        m_armed = 0;
      end else if (in_valid) begin
        m_bits.push_back(din);
        if (m_bits.size() > 32) void'(m_bits.pop_front());
        m_fresh++;
        hit = 0;
        if (m_fresh >= m_len) begin
          hit = 1;
          for (int k = 0; k < m_len; k++)
            if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 0;
        end
        if (hit) begin
          m_det = 1;
          m_matches++;
          if (!m_ovl) m_fresh = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_valid = 1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    tick();
    cfg_valid = 0;
  endtask

  task automatic do_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic do_disarm();
    disarm = 1; tick(); disarm = 0;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1; din = b; tick(); in_valid = 0;
  endtask

  task automatic test_reset();
    reset = 0; tick(); tick();
    checks++;
    if ({cfg_ready, armed, detect, cfg_err, count_sat} !== 5'b10000 || match_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b arm=%b det=%b err=%b sat=%b cnt=%0d required rdy=1 others 0",
               cfg_ready, armed, detect, cfg_err, count_sat, match_count);
    end
    reset = 1; tick();
    checks++;
    if (armed !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got armed=%b rdy=%b required 0/1", armed, cfg_ready);
    end
    do_arm();
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL arm_after_reset: got armed=%b required 0", armed);
    end
  endtask

  task automatic test_overlap();
    bit s[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    bit e[9] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
    do_cfg(8'h05, 4'd4, 1'b1);
    do_arm();
    checks++;
    if (armed !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL overlap_armed: got armed=%b rdy=%b required 1/0", armed, cfg_ready);
    end
    for (int i = 0; i < 9; i++) begin
      send_bit(s[i]);
      checks++;
      if (detect !== e[i]) begin
        errors++;
        $display("FAIL overlap_detect bit%0d: got %b required %b", i + 1, detect, e[i]);
      end
    end
    checks++;
    if (match_count !== 8'd3) begin
      errors++;
      $display("FAIL overlap_count: got %0d required 3", match_count);
    end
  endtask

  task automatic test_nonoverlap();
    bit s[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    bit e[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    do_disarm();
    do_cfg(8'h05, 4'd4, 1'b0);
    do_arm();
    for (int i = 0; i < 9; i++) begin
      send_bit(s[i]);
      checks++;
      if (detect !== e[i]) begin
        errors++;
        $display("FAIL nonoverlap_detect bit%0d: got %b required %b", i + 1, detect, e[i]);
      end
    end
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL nonoverlap_count: got %0d required 2", match_count);
    end
  endtask

  task automatic test_gaps();
    // valid flag, bit value, detect expected after the edge
    bit v[7] = '{1, 0, 1, 0, 0, 1, 0};
    bit b[7] = '{1, 0, 1, 0, 0, 0, 0};
    bit e[7] = '{0, 0, 0, 0, 0, 1, 0};
    do_disarm();
    do_cfg(8'h06, 4'd3, 1'b1);
    do_arm();
    for (int i = 0; i < 7; i++) begin
      in_valid = v[i]; din = b[i]; tick(); in_valid = 0;
      checks++;
      if (detect !== e[i]) begin
        errors++;
        $display("FAIL gaps_detect step%0d: got %b required %b", i, detect, e[i]);
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL gaps_count: got %0d required 1", match_count);
    end
  endtask

  task automatic test_cfg_err();
    do_disarm();
    do_cfg(8'h05, 4'd0, 1'b0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_len0: got %b required 1", cfg_err);
    end
    do_arm();
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL arm_len0: got armed=%b required 0", armed);
    end
    do_cfg(8'h05, 4'd9, 1'b0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_len9: got %b required 1", cfg_err);
    end
    do_arm();
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL arm_len9: got armed=%b required 0", armed);
    end
    do_cfg(8'hA5, 4'd8, 1'b0);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_len8: got %b required 0", cfg_err);
    end
    do_cfg(8'h05, 4'd4, 1'b1);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_len4: got %b required 0", cfg_err);
    end
    // config and arm together: config lands, arm is dropped
    cfg_valid = 1; arm = 1; cfg_len = 4'd4; tick(); cfg_valid = 0; arm = 0;
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL cfg_arm_same_cycle: got armed=%b required 0", armed);
    end
    do_arm();
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL arm_valid: got armed=%b required 1", armed);
    end
    do_cfg(8'h00, 4'd0, 1'b0);
    checks++;
    if (cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_while_armed: got err=%b rdy=%b required 0/0", cfg_err, cfg_ready);
    end
  endtask

  task automatic test_saturation();
    int sc[5]  = '{1, 2, 3, 3, 3};
    bit ss[5]  = '{0, 0, 1, 1, 1};
    do_disarm();
    do_cfg(8'h01, 4'd1, 1'b0);
    do_arm();
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      checks++;
      if (int'(s_match_count) != sc[i] || s_count_sat !== ss[i] || s_detect !== 1'b1) begin
        errors++;
        $display("FAIL sat_small step%0d: got cnt=%0d sat=%b det=%b required cnt=%0d sat=%b det=1",
                 i, s_match_count, s_count_sat, s_detect, sc[i], ss[i]);
      end
      checks++;
      if (int'(match_count) != i + 1 || count_sat !== 1'b0) begin
        errors++;
        $display("FAIL sat_wide step%0d: got cnt=%0d sat=%b required cnt=%0d sat=0",
                 i, match_count, count_sat, i + 1);
      end
    end
    send_bit(1'b0);
    checks++;
    if (detect !== 1'b0) begin
      errors++;
      $display("FAIL len1_zero_bit: got detect=%b required 0", detect);
    end
    do_disarm();
    checks++;
    if (match_count !== 8'd5 || s_match_count !== 2'd3 || s_count_sat !== 1'b1) begin
      errors++;
      $display("FAIL count_hold_idle: got %0d/%0d sat=%b required 5/3 sat=1",
               match_count, s_match_count, s_count_sat);
    end
    do_arm();
    checks++;
    if (s_match_count !== 2'd0 || s_count_sat !== 1'b0 || match_count !== 8'd0) begin
      errors++;
      $display("FAIL rearm_clear: got %0d/%0d sat=%b required 0/0 sat=0",
               match_count, s_match_count, s_count_sat);
    end
  endtask

  task automatic test_disarm_priority();
    do_disarm();
    do_cfg(8'h05, 4'd4, 1'b1);
    do_arm();
    send_bit(0); send_bit(1); send_bit(0);
    in_valid = 1; din = 1; disarm = 1; tick(); in_valid = 0; disarm = 0;
    checks++;
    if (detect !== 1'b0 || match_count !== 8'd0 || armed !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL disarm_priority: got det=%b cnt=%0d armed=%b rdy=%b required 0/0/0/1",
               detect, match_count, armed, cfg_ready);
    end
    do_arm();
    send_bit(0); send_bit(1); send_bit(0);
    reset = 0; in_valid = 1; din = 1; tick(); in_valid = 0; reset = 1;
    checks++;
    if ({cfg_ready, armed, detect, cfg_err, count_sat} !== 5'b10000 || match_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got rdy=%b arm=%b det=%b err=%b sat=%b cnt=%0d required rdy=1 others 0",
               cfg_ready, armed, detect, cfg_err, count_sat, match_count);
    end
    do_arm();
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL arm_after_mid_reset: got armed=%b required 0", armed);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom_range(0, 299) != 0);
      cfg_valid   = ($urandom_range(0, 19) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      cfg_overlap = 1'($urandom);
      arm         = ($urandom_range(0, 9) == 0);
      disarm      = ($urandom_range(0, 79) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      din         = 1'($urandom);
      tick();
      checks++;
      if (cfg_ready !== !m_armed || armed !== m_armed || cfg_err !== m_err) begin
        errors++;
        $display("FAIL rand_ctrl cyc%0d: got rdy=%b armed=%b err=%b required rdy=%b armed=%b err=%b",
                 n, cfg_ready, armed, cfg_err, !m_armed, m_armed, m_err);
      end
      checks++;
      if (detect !== m_det || s_detect !== m_det) begin
        errors++;
        $display("FAIL rand_detect cyc%0d: got %b/%b required %b", n, detect, s_detect, m_det);
      end
      checks++;
      if (int'(match_count) != exp_cnt(255) || count_sat !== (m_matches >= 255)) begin
        errors++;
        $display("FAIL rand_count cyc%0d: got cnt=%0d sat=%b required cnt=%0d sat=%b",
                 n, match_count, count_sat, exp_cnt(255), (m_matches >= 255));
      end
      checks++;
      if (int'(s_match_count) != exp_cnt(3) || s_count_sat !== (m_matches >= 3)) begin
        errors++;
        $display("FAIL rand_count_small cyc%0d: got cnt=%0d sat=%b required cnt=%0d sat=%b",
                 n, s_match_count, s_count_sat, exp_cnt(3), (m_matches >= 3));
      end
    end
    reset = 1; cfg_valid = 0; arm = 0; disarm = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gaps();
    test_cfg_err();
    test_saturation();
    test_disarm_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
